// File: rtl/multi_clock_divider.sv
// NUM_CH independent runtime-configurable clock dividers sharing clk_in, each with a toggle/pulse output and a tick enable.
// Optional CLKDIV_SYNC_EN adds sync_start, which phase-aligns every channel in one cycle.
module multi_clock_divider #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 50000000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_start,
`endif
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam int NSEL = 1 << CH_W;
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q      [NUM_CH];
  logic [CNT_W-1:0] div_q      [NUM_CH];
  logic [CNT_W-1:0] shadow_div [NUM_CH];
  logic [NUM_CH-1:0] mode_q;
  logic [NUM_CH-1:0] shadow_mode;
  logic [NUM_CH-1:0] pending;

  logic [NSEL-1:0]   pend_ext;
  logic              accept;
  logic              bad_req;
  logic              sync;
  logic [NUM_CH-1:0] tc;
  logic [NUM_CH-1:0] apply;
  logic [NUM_CH-1:0] mode_chg;
  logic [NUM_CH-1:0] wr;

`ifdef CLKDIV_SYNC_EN
  assign sync = sync_start;
`else
  assign sync = 1'b0;
`endif

  // Config handshake: a request transfers on any clk_in edge where cfg_valid && cfg_ready.
  // cfg_ready only deasserts while the addressed channel still holds an unapplied request;
  // out-of-range channels always look ready so the bad request is consumed and flagged.
  always_comb begin
    pend_ext = '0;
    pend_ext[NUM_CH-1:0] = pending;
    cfg_ready = ~pend_ext[cfg_ch];
    accept    = cfg_valid & cfg_ready;
    bad_req   = (cfg_div == '0) || (32'(cfg_ch) >= NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      tc[i]       = ch_en[i] && (cnt_q[i] == div_q[i] - CNT_W'(1));
      // The old pending value is used, so a request landing on a TC edge waits for the next TC.
      apply[i]    = pending[i] & (sync | ~ch_en[i] | tc[i]);
      mode_chg[i] = apply[i] & (shadow_mode[i] != mode_q[i]);
      wr[i]       = accept & ~bad_req & (cfg_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cfg_err <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]       <= '0;
        div_q[i]       <= DEF_DIV;
        shadow_div[i]  <= DEF_DIV;
        mode_q[i]      <= 1'b0;
        shadow_mode[i] <= 1'b0;
        pending[i]     <= 1'b0;
        clk_out[i]     <= 1'b0;
        tick[i]        <= 1'b0;
      end
    end else begin
      cfg_err <= accept & bad_req;
      for (int i = 0; i < NUM_CH; i++) begin
        if (apply[i]) begin
          div_q[i]   <= shadow_div[i];
          mode_q[i]  <= shadow_mode[i];
          pending[i] <= 1'b0;
        end else if (wr[i]) begin
          shadow_div[i]  <= cfg_div;
          shadow_mode[i] <= cfg_mode;
          pending[i]     <= 1'b1;
        end

        if (sync || !ch_en[i]) begin
          cnt_q[i]   <= '0;
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
        end else if (tc[i]) begin
          cnt_q[i] <= '0;
          tick[i]  <= 1'b1;
          // A mode switch restarts the output from low; otherwise follow the current mode.
          if (mode_chg[i])    clk_out[i] <= 1'b0;
          else if (mode_q[i]) clk_out[i] <= 1'b1;
          else                clk_out[i] <= ~clk_out[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          tick[i]  <= 1'b0;
          if (mode_q[i]) clk_out[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider (3 channels, ch2 kept disabled, DEFAULT_DIV=4).
module tb_multi_clock_divider;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;

  logic              clk_in = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] ch_en;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_mode;
  logic              cfg_err;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
`ifdef CLKDIV_SYNC_EN
  logic              sync_start;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] tk [NUM_CH];
  logic [31:0] co [NUM_CH];
  logic [31:0] rdy;

  multi_clock_divider #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .DEFAULT_DIV(4)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
`ifdef CLKDIV_SYNC_EN
    .sync_start(sync_start),
`endif
    .ch_en(ch_en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_mode(cfg_mode),
    .cfg_err(cfg_err),
    .clk_out(clk_out),
    .tick(tick)
  );

  // clock / reset block
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_next(input string tag, input logic [31:0] obs);
    check(tag, obs, exp_q.pop_front());
  endtask

  task automatic capture(input int n);
    for (int c = 0; c < NUM_CH; c++) begin
      tk[c] = '0;
      co[c] = '0;
    end
    rdy = '0;
    for (int i = 0; i < n; i++) begin
      step();
      cfg_valid = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        tk[c][i] = tick[c];
        co[c][i] = clk_out[c];
      end
      rdy[i] = cfg_ready;
    end
  endtask

  task automatic send(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] dv, input logic md);
    cfg_ch    = ch;
    cfg_div   = dv;
    cfg_mode  = md;
    cfg_valid = 1'b1;
  endtask

  initial begin
    int w;
    rst = 1'b1;
    ch_en = '0;
    cfg_valid = 1'b0;
    cfg_ch = '0;
    cfg_div = '0;
    cfg_mode = 1'b0;
`ifdef CLKDIV_SYNC_EN
    sync_start = 1'b0;
`endif
    repeat (3) step();
    check("rst_clk_out", 32'(clk_out), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_err", 32'(cfg_err), 32'h0);

    // default divisor 4, toggle mode, both channels enabled
    rst = 1'b0;
    ch_en = 3'b011;
    capture(16);
    exp_q.push_back(32'hFFFF);
    exp_q.push_back(32'h8888); exp_q.push_back(32'h7878);
    exp_q.push_back(32'h8888); exp_q.push_back(32'h7878);
    exp_q.push_back(32'h0);    exp_q.push_back(32'h0);
    check_next("ready_after_rst", rdy);
    check_next("ch0_tick_div4", tk[0]);
    check_next("ch0_clk_div4", co[0]);
    check_next("ch1_tick_div4", tk[1]);
    check_next("ch1_clk_div4", co[1]);
    check_next("ch2_tick_off", tk[2]);
    check_next("ch2_clk_off", co[2]);

    // ch1 -> div 3 pulse mode while running
    send(2'd1, 8'd3, 1'b1);
    check("ready_pre_cfg", 32'(cfg_ready), 32'h1);
    step();
    cfg_valid = 1'b0;
    check("ready_pending", 32'(cfg_ready), 32'h0);
    check("err_good_cfg", 32'(cfg_err), 32'h0);
    capture(12);
    check("ch1_tick_apply", tk[1], 32'h924);
    check("ch1_clk_apply", co[1], 32'h920);
    check("ch1_ready_apply", rdy, 32'hFFC);
    check("ch0_tick_undisturbed", tk[0], 32'h444);
    check("ch0_clk_undisturbed", co[0], 32'hC3C);

    // rejected requests
    send(2'd0, 8'd0, 1'b1);
    step();
    cfg_valid = 1'b0;
    check("err_div0", 32'(cfg_err), 32'h1);
    check("ready_div0", 32'(cfg_ready), 32'h1);
    step();
    check("err_one_cycle", 32'(cfg_err), 32'h0);
    send(2'd3, 8'd5, 1'b0);
    check("ready_oob", 32'(cfg_ready), 32'h1);
    step();
    cfg_valid = 1'b0;
    check("err_oob", 32'(cfg_err), 32'h1);
    cfg_ch = 2'd0;
    capture(12);
    check("rej_ch0_ticks", 32'($countones(tk[0])), 32'd3);
    check("rej_ch1_ticks", 32'($countones(tk[1])), 32'd4);
    check("rej_ch1_pulses", 32'($countones(co[1])), 32'd4);
    check("rej_no_pending", rdy, 32'hFFF);
    check("rej_ch2_idle", tk[2] | co[2], 32'h0);

    // div = 1 toggle on ch0
    send(2'd0, 8'd1, 1'b0);
    step();
    cfg_valid = 1'b0;
    w = 0;
    while (!cfg_ready && w < 10) begin
      step();
      w++;
    end
    check("div1_applied", 32'(cfg_ready), 32'h1);
    capture(6);
    check("div1_tick_held", tk[0], 32'h3F);
    check("div1_alternate", (co[0] ^ (co[0] >> 1)) & 32'h1F, 32'h1F);
    ch_en = 3'b010;
    step();
    check("dis_clk", 32'(clk_out[0]), 32'h0);
    check("dis_tick", 32'(tick[0]), 32'h0);

    // configuration while disabled applies at once; first tick div edges after re-enable
    send(2'd0, 8'd4, 1'b0);
    step();
    cfg_valid = 1'b0;
    check("dis_pending", 32'(cfg_ready), 32'h0);
    step();
    check("dis_apply", 32'(cfg_ready), 32'h1);
    ch_en = 3'b011;
    capture(8);
    check("reen_tick", tk[0], 32'h88);
    check("reen_clk", co[0], 32'h78);

    // request accepted on the TC edge waits for the next TC
    repeat (3) step();
    send(2'd0, 8'd2, 1'b0);
    capture(10);
    check("tc_accept_tick", tk[0], 32'h151);
    check("tc_accept_clk", co[0], 32'h0CF);
    check("tc_accept_ready", rdy, 32'h3F0);

    // reset mid-count discards pending config
    send(2'd1, 8'd7, 1'b0);
    step();
    cfg_valid = 1'b0;
    check("pend_before_rst", 32'(cfg_ready), 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_outputs", 32'({clk_out, tick}), 32'h0);
    check("rst_clear_pending", 32'(cfg_ready), 32'h1);
    capture(8);
    check("post_rst_ch0_tick", tk[0], 32'h88);
    check("post_rst_ch1_tick", tk[1], 32'h88);
    check("post_rst_ch1_clk", co[1], 32'h78);

`ifdef CLKDIV_SYNC_EN
    // pending ch1 div 6 applied by sync_start, then ticks coincide at the LCM
    step();
    send(2'd1, 8'd6, 1'b0);
    step();
    cfg_valid = 1'b0;
    sync_start = 1'b1;
    step();
    sync_start = 1'b0;
    check("sync_outputs", 32'({clk_out, tick}), 32'h0);
    check("sync_apply", 32'(cfg_ready), 32'h1);
    capture(12);
    check("sync_ch0_tick", tk[0], 32'h888);
    check("sync_ch1_tick", tk[1], 32'h820);
    check("sync_coincide", tk[0] & tk[1], 32'h800);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
